// File: rtl/count_event_gen_pkg.sv
// Shared definitions for the strobe generator and its shadow of the dual event counter.
// DIV and TOT_W defaults are common with the dual counter itself.
package count_event_gen_pkg;

    localparam int DIV_DEF   = 4;
    localparam int TOT_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/count_event_gen_shadow.sv
// Shadow of the dual event counter: Total0 counts Slt=0 strobes,
// Total1 counts every DIV-th Slt=1 strobe.
module evt_shadow_counter
    import count_event_gen_pkg::*;
#(
    parameter int DIV   = DIV_DEF,
    parameter int TOT_W = TOT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Slt,
    output logic [TOT_W-1:0] Total0,
    output logic [TOT_W-1:0] Total1
);

    localparam int PH_W = $clog2(DIV);

    logic [PH_W-1:0]  r_phase;
    logic [TOT_W-1:0] r_tot0;
    logic [TOT_W-1:0] r_tot1;

    // Phase wraps naturally because DIV is a power of two.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase <= '0;
            r_tot0  <= '0;
            r_tot1  <= '0;
        end else if (En) begin
            if (!Slt) begin
                r_tot0 <= r_tot0 + TOT_W'(1);
            end else begin
                r_phase <= r_phase + PH_W'(1);
                if (r_phase == PH_W'(DIV - 1)) begin
                    r_tot1 <= r_tot1 + TOT_W'(1);
                end
            end
        end
    end

    assign Total0 = r_tot0;
    assign Total1 = r_tot1;

endmodule

// File: rtl/count_event_gen.sv
// Command-driven Slt/En strobe generator: handshake, IDLE/EMIT/GAP FSM and
// remaining/gap counters, plus the shadow totals of the attached counter.
module count_event_gen
    import count_event_gen_pkg::*;
#(
    parameter int DIV   = DIV_DEF,
    parameter int CNT_W = 16,
    parameter int GAP_W = 8,
    parameter int TOT_W = TOT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic             CmdSlt,
    input  logic [CNT_W-1:0] CmdCount,
    input  logic [GAP_W-1:0] CmdGap,
    output logic             Slt,
    output logic             En,
    output logic             Busy,
    output logic             Done,
    output logic [TOT_W-1:0] Total0,
    output logic [TOT_W-1:0] Total1
);

    localparam int DIV_LOG = $clog2(DIV);
    localparam int REM_W   = CNT_W + DIV_LOG;

    state_t           r_state;
    state_t           w_next;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_next;
    logic [REM_W-1:0] w_cmd_ext;
    logic [REM_W-1:0] w_cmd_rem;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] w_gap_len_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_next;
    logic             r_slt;
    logic             w_slt_next;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic             w_done_next;

    // Next-state, counter and strobe decisions for the current cycle.
    always_comb begin
        w_next         = r_state;
        w_rem_next     = r_rem;
        w_gap_len_next = r_gap_len;
        w_gap_cnt_next = r_gap_cnt;
        w_slt_next     = r_slt;
        w_done_next    = 1'b0;
        w_cmd_ext      = REM_W'(CmdCount);
        // Slt=1 commands need DIV strobes per unit.
        if (CmdSlt) begin
            w_cmd_rem = w_cmd_ext << DIV_LOG;
        end else begin
            w_cmd_rem = w_cmd_ext;
        end
        case (r_state)
            ST_IDLE: begin
                if (CmdValid) begin
                    w_slt_next     = CmdSlt;
                    w_gap_len_next = CmdGap;
                    w_rem_next     = w_cmd_rem;
                    if (w_cmd_rem == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_next = ST_EMIT;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_EMIT: begin
                w_rem_next = r_rem - REM_W'(1);
                if (r_rem == REM_W'(1)) begin
                    w_next      = ST_IDLE;
                    w_done_next = 1'b1;
                end else if (r_gap_len != '0) begin
                    w_next         = ST_GAP;
                    w_gap_cnt_next = r_gap_len;
                end else begin
                    w_next = ST_EMIT;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_next = ST_EMIT;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered strobe outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_gap_len <= '0;
            r_gap_cnt <= '0;
            r_slt     <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rem     <= w_rem_next;
            r_gap_len <= w_gap_len_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_slt     <= w_slt_next;
            r_en      <= (w_next == ST_EMIT);
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= w_done_next;
        end
    end

    assign CmdReady = (r_state == ST_IDLE);
    assign Slt      = r_slt;
    assign En       = r_en;
    assign Busy     = r_busy;
    assign Done     = r_done;

    evt_shadow_counter #(
        .DIV   (DIV),
        .TOT_W (TOT_W)
    ) u_shadow (
        .Clk    (Clk),
        .Reset  (Reset),
        .En     (r_en),
        .Slt    (r_slt),
        .Total0 (Total0),
        .Total1 (Total1)
    );

endmodule
